reg_wb_scheduler: RTL and testbench
===================================

Name: reg_wb_scheduler

Overview:
- Schedules the single write port of the 32x32 register file and tracks pending destination registers (scoreboard).
- Arbitrates writebacks from the ALU and from the load/memory unit onto the port. The memory unit has fixed priority; a one-entry skid buffer holds a deferred ALU result.
- Produces an issue stall for RAW and WAW hazards, because the register file has no internal bypass.
- Sits between the decode/issue stage, the execute/memory writeback paths, and the register file write port (regWrite/A3/WD).

Parameters:
XLEN, 32, data width of register file entries
NREG, 32, number of architectural registers (address width fixed at 5)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
issue_valid  in  1  decode presents an instruction
issue_rd  in  5  destination register of presented instruction
issue_rs1  in  5  source register 1
issue_rs2  in  5  source register 2
issue_use_rs1  in  1  instruction reads rs1
issue_use_rs2  in  1  instruction reads rs2
issue_writes  in  1  instruction writes rd
issue_stall  out  1  hold decode; instruction not accepted this cycle
alu_wb_valid  in  1  ALU result available
alu_wb_rd  in  5  ALU destination
alu_wb_data  in  XLEN  ALU result
alu_wb_ready  out  1  ALU result accepted this cycle
mem_wb_valid  in  1  load result available (always accepted)
mem_wb_rd  in  5  load destination
mem_wb_data  in  XLEN  load data
flush  in  1  synchronous clear of scoreboard and skid buffer
rf_regWrite  out  1  register file write enable (registered)
rf_A3  out  5  register file write address (registered)
rf_WD  out  XLEN  register file write data (registered)
busy_mask  out  NREG  scoreboard, bit i = write pending to xi
wb_err  out  1  sticky: a writeback committed to a non-busy register

Behaviour:
- Reset (async): busy_mask=0, skid empty, rf_regWrite=0, rf_A3=0, rf_WD=0, wb_err=0. Any in-flight skid entry is discarded.
- Issue accept: issue_valid && !issue_stall.
- issue_stall (combinational) asserts when issue_valid and any of:
  - issue_use_rs1 && busy[rs1]
  - issue_use_rs2 && busy[rs2]
  - issue_writes && busy[rd]
- busy[0] is hard-wired 0. x0 never stalls and is never marked busy.
- Accepted issue with issue_writes and rd!=0 sets busy[rd] at the next edge.
- Write port selection, each cycle, priority order:
  - mem_wb if mem_wb_valid
  - else the skid entry if valid
  - else alu_wb if alu_wb_valid && alu_wb_ready
- The winner is registered onto rf_regWrite/rf_A3/rf_WD at the next edge. Latency from acceptance to RF write enable is 1 cycle; the RF captures one cycle later.
- alu_wb_ready = !skid_valid.
- If mem_wb and an accepted alu_wb occur in the same cycle, the ALU entry is captured into the skid buffer. The skid entry drains on the next cycle without mem_wb. ALU results therefore commit in order.
- Writebacks with rd=0 are accepted and consumed, but produce rf_regWrite=0 and have no scoreboard effect.
- busy[rd] clears on the edge where rf_regWrite=1 with rf_A3=rd. This is the same edge at which the RF stores the data, so a dependent instruction issues the following cycle and reads the new value.
- Simultaneous set (new issue) and clear (commit) of the same rd: set wins. This case is unreachable while the WAW stall is correct, but the rule is defined.
- Commit with busy[rd]=0 and rd!=0 sets wb_err. wb_err is cleared only by reset.
- flush: at the next edge, busy_mask=0 and the skid buffer is emptied. The registered write port still completes the write already presented that cycle. flush has priority over set/clear.
- A skid entry never stalls mem_wb. The memory path must not be back-pressured.

Decomposition:
- Shared package: XLEN, REG_ADDR_W=5, NREG=32, X0 address constant, and a wb_req typedef (valid, rd, data) used by the ALU, memory and skid paths.
- One sub-module: wb_skid_buffer, a one-entry buffer with load/drain/flush and a valid flag that drives alu_wb_ready.

Test Plan:
- Reset mid-run with skid full and busy_mask=0x0000_0004 -> all outputs 0 immediately; after release alu_wb_ready=1.
- Issue rd=5 (busy[5]=1); next issue rs1=5 -> issue_stall=1. ALU writeback rd=5 data=0x1234_5678 -> rf_regWrite=1, A3=5, WD=0x12345678 one cycle later. busy[5] clears at that edge; stall drops the next cycle.
- Same-cycle mem_wb rd=3 data=0xAAAA_0000 and alu_wb rd=4 data=0x0000_BBBB -> cycle N+1 writes x3. Skid holds x4 with alu_wb_ready=0; cycle N+2 writes x4 and alu_wb_ready returns to 1.
- Back-to-back mem_wb for 3 cycles while ALU result pending in skid -> skid waits, no loss, and x-writes appear in order: mem, mem, mem, then skid.
- Issue rd=0 and alu_wb rd=0 data=0xFFFF_FFFF -> no stall, busy_mask unchanged, rf_regWrite stays 0, wb_err=0.
- Writeback rd=7 with busy[7]=0 -> x7 written and wb_err=1 sticky. flush with busy_mask=0x0000_00F0 -> busy_mask=0 next cycle.

Source files
------------

// File: rtl/reg_wb_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_wb_scheduler_pkg
// Description : Shared widths, the x0 address constant and the writeback
//               request record used by the ALU, memory and skid paths of
//               the register-file write scheduler.
// Revision    : 1.0  initial release
// ============================================================================
package reg_wb_scheduler_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREG       = 32;

  localparam logic [REG_ADDR_W-1:0] X0_ADDR = '0;

  // One writeback candidate: destination register plus result word.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage : reg_wb_scheduler_pkg
`default_nettype wire

// File: rtl/reg_wb_scheduler_wb_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : wb_skid_buffer
// Description : One-entry holding buffer for an ALU writeback that lost
//               arbitration to the memory path.
// Ports       : clk, reset (async, active-high)
//               load/load_req - capture an entry (only issued while empty)
//               drain         - entry consumed by the write port
//               flush         - discard the entry
//               entry         - held entry; entry.valid is the full flag
// Revision    : 1.0  initial release
// ============================================================================
module wb_skid_buffer
  import reg_wb_scheduler_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    load,
  input  wb_req_t load_req,
  input  logic    drain,
  input  logic    flush,
  output wb_req_t entry
);

  logic                  valid_q, valid_d;
  logic [REG_ADDR_W-1:0] rd_q,    rd_d;
  logic [XLEN-1:0]       data_q,  data_d;

  // Load only happens while empty (the ALU is back-pressured otherwise),
  // so load and drain are never requested together.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      rd_d    = load_req.rd;
      data_d  = load_req.data;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  assign entry = '{valid: valid_q, rd: rd_q, data: data_q};

endmodule : wb_skid_buffer
`default_nettype wire

// File: rtl/reg_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : reg_wb_scheduler
// Description : Owns the single register-file write port. Arbitrates the
//               memory (fixed priority) and ALU writebacks, parks a losing
//               ALU result in a one-entry skid buffer, and keeps a pending-
//               write scoreboard that stalls issue on RAW/WAW hazards.
// Ports       : issue_*      - decode stage request, issue_stall back
//               alu_wb_*     - ALU writeback with ready handshake
//               mem_wb_*     - load writeback, never back-pressured
//               flush        - clears scoreboard and skid buffer
//               rf_*         - registered register-file write port
//               busy_mask    - scoreboard, wb_err - sticky bad-commit flag
// Revision    : 1.0  initial release
// ============================================================================
module reg_wb_scheduler
  import reg_wb_scheduler_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  input  logic                  issue_use_rs1,
  input  logic                  issue_use_rs2,
  input  logic                  issue_writes,
  output logic                  issue_stall,
  input  logic                  alu_wb_valid,
  input  logic [REG_ADDR_W-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]       alu_wb_data,
  output logic                  alu_wb_ready,
  input  logic                  mem_wb_valid,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd,
  input  logic [XLEN-1:0]       mem_wb_data,
  input  logic                  flush,
  output logic                  rf_regWrite,
  output logic [REG_ADDR_W-1:0] rf_A3,
  output logic [XLEN-1:0]       rf_WD,
  output logic [NREG-1:0]       busy_mask,
  output logic                  wb_err
);

  logic [NREG-1:0]       busy_q,   busy_d;
  logic                  wb_err_q, wb_err_d;
  logic                  rf_we_q,  rf_we_d;
  logic [REG_ADDR_W-1:0] rf_a3_q,  rf_a3_d;
  logic [XLEN-1:0]       rf_wd_q,  rf_wd_d;

  wb_req_t mem_req, alu_req, skid_entry, sel;
  logic    alu_accept, skid_load, skid_drain, issue_accept;

  assign mem_req = '{valid: mem_wb_valid, rd: mem_wb_rd, data: mem_wb_data};
  assign alu_req = '{valid: alu_wb_valid, rd: alu_wb_rd, data: alu_wb_data};

  assign alu_wb_ready = !skid_entry.valid;
  assign alu_accept   = alu_wb_valid && alu_wb_ready;
  // An accepted ALU result that collides with a load is parked; the parked
  // entry leaves on the first cycle the memory path is quiet.
  assign skid_load    = mem_wb_valid && alu_accept;
  assign skid_drain   = !mem_wb_valid && skid_entry.valid;

  wb_skid_buffer u_skid (
    .clk      (clk),
    .reset    (reset),
    .load     (skid_load),
    .load_req (alu_req),
    .drain    (skid_drain),
    .flush    (flush),
    .entry    (skid_entry)
  );

  // Write-port winner: memory, then the parked ALU entry, then a fresh ALU
  // result. A parked entry blocks fresh ALU results, preserving ALU order.
  always_comb begin
    sel = '0;
    if (mem_wb_valid) begin
      sel = mem_req;
    end else if (skid_entry.valid) begin
      sel = skid_entry;
    end else if (alu_accept) begin
      sel = alu_req;
    end
  end

  // busy_q[0] is never set, so x0 operands can never stall.
  assign issue_stall = issue_valid &&
                       ((issue_use_rs1 && busy_q[issue_rs1]) ||
                        (issue_use_rs2 && busy_q[issue_rs2]) ||
                        (issue_writes  && busy_q[issue_rd]));
  assign issue_accept = issue_valid && !issue_stall;

  always_comb begin
    busy_d   = busy_q;
    wb_err_d = wb_err_q;
    // Clear on the edge the RF stores the value; rf_we_q implies rd != x0.
    if (rf_we_q) begin
      if (!busy_q[rf_a3_q]) begin
        wb_err_d = 1'b1;
      end
      busy_d[rf_a3_q] = 1'b0;
    end
    // Applied after the clear so a same-register set wins.
    if (issue_accept && issue_writes && (issue_rd != X0_ADDR)) begin
      busy_d[issue_rd] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  // Writes to x0 are consumed here without enabling the RF.
  always_comb begin
    rf_we_d = sel.valid && (sel.rd != X0_ADDR);
    rf_a3_d = sel.rd;
    rf_wd_d = sel.data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= '0;
      wb_err_q <= 1'b0;
      rf_we_q  <= 1'b0;
      rf_a3_q  <= '0;
      rf_wd_q  <= '0;
    end else begin
      busy_q   <= busy_d;
      wb_err_q <= wb_err_d;
      rf_we_q  <= rf_we_d;
      rf_a3_q  <= rf_a3_d;
      rf_wd_q  <= rf_wd_d;
    end
  end

  assign busy_mask   = busy_q;
  assign wb_err      = wb_err_q;
  assign rf_regWrite = rf_we_q;
  assign rf_A3       = rf_a3_q;
  assign rf_WD       = rf_wd_q;

endmodule : reg_wb_scheduler
`default_nettype wire

// File: tb/tb_reg_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_wb_scheduler
// Description : Self-checking bench for reg_wb_scheduler. Directed scenarios
//               followed by randomized traffic, all compared each cycle
//               against a queue-based behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_reg_wb_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_use_rs1, issue_use_rs2, issue_writes;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_stall;
  logic        alu_wb_valid, alu_wb_ready;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        mem_wb_valid;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_data;
  logic        flush;
  logic        rf_regWrite;
  logic [4:0]  rf_A3;
  logic [31:0] rf_WD;
  logic [31:0] busy_mask;
  logic        wb_err;

  reg_wb_scheduler dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_use_rs1(issue_use_rs1),
    .issue_use_rs2(issue_use_rs2), .issue_writes(issue_writes),
    .issue_stall(issue_stall),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd),
    .alu_wb_data(alu_wb_data), .alu_wb_ready(alu_wb_ready),
    .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd),
    .mem_wb_data(mem_wb_data), .flush(flush),
    .rf_regWrite(rf_regWrite), .rf_A3(rf_A3), .rf_WD(rf_WD),
    .busy_mask(busy_mask), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: pending set, FIFO of parked ALU results, port image.
  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
  logic [31:0] m_busy;
  ent_t        m_skid[$];
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  logic        m_err;
  logic [4:0]  wlog[$];

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    issue_use_rs1 = 0; issue_use_rs2 = 0; issue_writes = 0;
    alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
    mem_wb_valid = 0; mem_wb_rd = 0; mem_wb_data = 0; flush = 0;
  endtask

  task automatic model_clear();
    m_busy = 0; m_skid.delete(); m_we = 0; m_a3 = 0; m_wd = 0; m_err = 0;
  endtask

  function automatic logic exp_stall();
    return issue_valid && ((issue_use_rs1 && m_busy[issue_rs1]) ||
                           (issue_use_rs2 && m_busy[issue_rs2]) ||
                           (issue_writes  && m_busy[issue_rd]));
  endfunction

  // One clock: compare at the falling edge, advance the model, cross the
  // rising edge and settle 1 time unit.
  task automatic step();
    logic st, acc, alu_acc, wv;
    ent_t w;
    @(negedge clk);
    st = exp_stall();
    check("issue_stall", {31'b0, issue_stall}, {31'b0, st});
    check("alu_wb_ready", {31'b0, alu_wb_ready}, {31'b0, m_skid.size() == 0});
    check("busy_mask", busy_mask, m_busy);
    check("rf_regWrite", {31'b0, rf_regWrite}, {31'b0, m_we});
    if (m_we) begin
      check("rf_A3", {27'b0, rf_A3}, {27'b0, m_a3});
      check("rf_WD", rf_WD, m_wd);
    end
    check("wb_err", {31'b0, wb_err}, {31'b0, m_err});
    if (rf_regWrite) wlog.push_back(rf_A3);

    acc     = issue_valid && !st;
    alu_acc = alu_wb_valid && (m_skid.size() == 0);
    wv      = 0;
    w       = '{rd: 0, data: 0};
    if (mem_wb_valid) begin
      w = '{rd: mem_wb_rd, data: mem_wb_data}; wv = 1;
      if (alu_acc) m_skid.push_back('{rd: alu_wb_rd, data: alu_wb_data});
    end else if (m_skid.size() != 0) begin
      w = m_skid.pop_front(); wv = 1;
    end else if (alu_acc) begin
      w = '{rd: alu_wb_rd, data: alu_wb_data}; wv = 1;
    end
    if (flush) m_skid.delete();
    if (m_we) begin
      if (!m_busy[m_a3]) m_err = 1;
      m_busy[m_a3] = 0;
    end
    if (acc && issue_writes && issue_rd != 0) m_busy[issue_rd] = 1;
    if (flush) m_busy = 0;
    m_we = wv && (w.rd != 0);
    m_a3 = w.rd;
    m_wd = w.data;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop at once.
  task automatic reset_now();
    idle();
    reset = 1;
    #1;
    model_clear();
    check("rst_regWrite", {31'b0, rf_regWrite}, 32'd0);
    check("rst_A3", {27'b0, rf_A3}, 32'd0);
    check("rst_WD", rf_WD, 32'd0);
    check("rst_busy", busy_mask, 32'd0);
    check("rst_err", {31'b0, wb_err}, 32'd0);
    @(posedge clk);
    #1;
    reset = 0;
    #1;
    check("rst_ready", {31'b0, alu_wb_ready}, 32'd1);
  endtask

  task automatic issue_w(input logic [4:0] rd);
    idle(); issue_valid = 1; issue_writes = 1; issue_rd = rd; step();
  endtask

  initial begin
    logic [31:0] mask_before;
    reset = 0;
    idle();
    reset_now();

    // RAW stall, ALU commit, scoreboard clear.
    issue_w(5);
    check("busy5_set", busy_mask, 32'h0000_0020);
    idle(); issue_valid = 1; issue_rs1 = 5; issue_use_rs1 = 1;
    alu_wb_valid = 1; alu_wb_rd = 5; alu_wb_data = 32'h1234_5678;
    step();
    check("raw_stall", {31'b0, issue_stall}, 32'd1);
    check("x5_we", {31'b0, rf_regWrite}, 32'd1);
    check("x5_A3", {27'b0, rf_A3}, 32'd5);
    check("x5_WD", rf_WD, 32'h1234_5678);
    alu_wb_valid = 0;
    step();
    check("busy5_clear", busy_mask, 32'd0);
    check("raw_release", {31'b0, issue_stall}, 32'd0);
    step();

    // Memory beats ALU; ALU result parked then drained.
    issue_w(3); issue_w(4);
    idle(); mem_wb_valid = 1; mem_wb_rd = 3; mem_wb_data = 32'hAAAA_0000;
    alu_wb_valid = 1; alu_wb_rd = 4; alu_wb_data = 32'h0000_BBBB;
    step();
    idle();
    check("coll_A3_mem", {27'b0, rf_A3}, 32'd3);
    check("coll_ready0", {31'b0, alu_wb_ready}, 32'd0);
    step();
    check("coll_A3_skid", {27'b0, rf_A3}, 32'd4);
    check("coll_WD_skid", rf_WD, 32'h0000_BBBB);
    check("coll_ready1", {31'b0, alu_wb_ready}, 32'd1);
    step();

    // Three back-to-back loads while an ALU result waits in the skid.
    issue_w(8); issue_w(9); issue_w(10); issue_w(11);
    wlog.delete();
    idle(); mem_wb_valid = 1; mem_wb_rd = 8; mem_wb_data = 32'h8;
    alu_wb_valid = 1; alu_wb_rd = 11; alu_wb_data = 32'hB;
    step();
    mem_wb_rd = 9;  mem_wb_data = 32'h9; step();
    mem_wb_rd = 10; mem_wb_data = 32'hA; step();
    idle(); step(); step(); step();
    check("order_len", wlog.size(), 32'd4);
    if (wlog.size() == 4) begin
      check("order0", {27'b0, wlog[0]}, 32'd8);
      check("order1", {27'b0, wlog[1]}, 32'd9);
      check("order2", {27'b0, wlog[2]}, 32'd10);
      check("order3", {27'b0, wlog[3]}, 32'd11);
    end

    // x0 destination: no stall, no scoreboard change, no RF write.
    mask_before = busy_mask;
    idle(); issue_valid = 1; issue_writes = 1; issue_rd = 0;
    alu_wb_valid = 1; alu_wb_rd = 0; alu_wb_data = 32'hFFFF_FFFF;
    check("x0_stall", {31'b0, issue_stall}, 32'd0);
    step();
    idle(); step();
    check("x0_mask", busy_mask, mask_before);
    check("x0_we", {31'b0, rf_regWrite}, 32'd0);
    check("x0_err", {31'b0, wb_err}, 32'd0);

    // Commit to a non-pending register, then flush a populated scoreboard.
    idle(); alu_wb_valid = 1; alu_wb_rd = 7; alu_wb_data = 32'h77; step();
    idle(); step(); step();
    check("err_set", {31'b0, wb_err}, 32'd1);
    issue_w(4); issue_w(5); issue_w(6); issue_w(7);
    check("pre_flush", busy_mask, 32'h0000_00F0);
    idle(); flush = 1; step();
    idle();
    check("flushed", busy_mask, 32'd0);
    check("err_sticky", {31'b0, wb_err}, 32'd1);
    step();

    // Reset while the skid is full and x2 is pending.
    issue_w(2);
    idle(); mem_wb_valid = 1; mem_wb_rd = 2; mem_wb_data = 32'h22;
    alu_wb_valid = 1; alu_wb_rd = 20; alu_wb_data = 32'h20;
    step();
    idle();
    check("pre_rst_busy", busy_mask, 32'h0000_0004);
    check("pre_rst_ready", {31'b0, alu_wb_ready}, 32'd0);
    reset_now();
    step();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) reset_now();
      idle();
      issue_valid   = ($urandom_range(0, 99) < 60);
      issue_rd      = 5'($urandom_range(0, 7));
      issue_rs1     = 5'($urandom_range(0, 7));
      issue_rs2     = 5'($urandom_range(0, 7));
      issue_use_rs1 = 1'($urandom_range(0, 1));
      issue_use_rs2 = 1'($urandom_range(0, 1));
      issue_writes  = 1'($urandom_range(0, 1));
      alu_wb_valid  = ($urandom_range(0, 99) < 50);
      alu_wb_rd     = 5'($urandom_range(0, 7));
      alu_wb_data   = $urandom;
      mem_wb_valid  = ($urandom_range(0, 99) < 30);
      mem_wb_rd     = 5'($urandom_range(0, 7));
      mem_wb_data   = $urandom;
      flush         = ($urandom_range(0, 99) < 3);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_reg_wb_scheduler
`default_nettype wire
